// File: rtl/color_daltonize.sv
// Three-stage daltonization pipeline for 24-bit RGB video.
// The red-channel error is redistributed into green and blue, and the sync/enable signals are delayed to stay aligned with the pixel.
module color_daltonize #(
    parameter int unsigned SHIFT_COEF = 179
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [1:0]  deficiency,
    input  logic [23:0] rgb_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    output logic [23:0] rgb_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic [1:0]  active_mode
);

    localparam int unsigned CW = 8;   // channel width
    localparam int unsigned EW = 9;   // signed error width
    localparam int unsigned KW = 10;  // signed scaled-error width
    localparam int unsigned SW = 11;  // signed pre-saturation width
    localparam int unsigned PW = 18;  // signed product width

    // Q0.8 weighted sum of two channels, using a 16-bit accumulator and keeping the integer part.
    function automatic logic [CW-1:0] sim8(input logic [7:0] a, input logic [7:0] x,
                                           input logic [7:0] b, input logic [7:0] y);
        logic [15:0] s;
        s = 16'(a) * 16'(x) + 16'(b) * 16'(y);
        return CW'(s >> 8);
    endfunction

    function automatic logic [CW-1:0] sat8(input logic signed [SW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > 11'sd255)
            return '1;
        else
            return v[CW-1:0];
    endfunction

    logic              vs_prev_q;
    logic [1:0]        active_mode_q, mode_d;

    logic [CW-1:0]     r1_q, g1_q, b1_q;
    logic [CW-1:0]     simr1_q, simg1_q, simb1_q;
    logic [CW-1:0]     simr_d, simg_d, simb_d;
    logic [1:0]        mode1_q;
    logic [2:0]        sync1_q, sync2_q, sync3_q;

    logic [CW-1:0]     r2_q;
    logic signed [SW-1:0] g2_q, b2_q, g2_d, b2_d;

    logic signed [EW-1:0] er_c, eg_c, eb_c;
    logic signed [PW-1:0] kprod_c;
    logic signed [KW-1:0] k_c;

    logic [23:0]       rgb_q, rgb_d;

    logic [CW-1:0]     r_in_c, g_in_c, b_in_c;

    assign r_in_c = rgb_in[23:16];
    assign g_in_c = rgb_in[15:8];
    assign b_in_c = rgb_in[7:0];

    // A vs rising edge latches the requested mode, and the pixel arriving on that cycle already uses it.
    assign mode_d = (vs_in && !vs_prev_q) ? deficiency : active_mode_q;

    always_comb begin
        simr_d = '0;
        simg_d = '0;
        simb_d = '0;
        case (mode_d)
            2'd1: begin
                simr_d = sim8(8'd160, r_in_c, 8'd96,  g_in_c);
                simg_d = sim8(8'd179, r_in_c, 8'd77,  g_in_c);
                simb_d = sim8(8'd77,  g_in_c, 8'd179, b_in_c);
            end
            2'd2: begin
                simr_d = sim8(8'd145, r_in_c, 8'd111, g_in_c);
                simg_d = sim8(8'd143, r_in_c, 8'd113, g_in_c);
                simb_d = sim8(8'd61,  g_in_c, 8'd194, b_in_c);
            end
            2'd3: begin
                simr_d = sim8(8'd243, r_in_c, 8'd13,  g_in_c);
                simg_d = sim8(8'd111, g_in_c, 8'd145, b_in_c);
                simb_d = sim8(8'd121, g_in_c, 8'd134, b_in_c);
            end
            default: ;
        endcase
    end

    // Compute the errors, scale the red error, and redistribute it into green and blue.
    always_comb begin
        er_c    = $signed({1'b0, r1_q}) - $signed({1'b0, simr1_q});
        eg_c    = $signed({1'b0, g1_q}) - $signed({1'b0, simg1_q});
        eb_c    = $signed({1'b0, b1_q}) - $signed({1'b0, simb1_q});
        kprod_c = $signed(PW'(SHIFT_COEF)) * PW'(er_c);
        k_c     = KW'(kprod_c >>> 8);
        g2_d    = $signed({3'b000, g1_q});
        b2_d    = $signed({3'b000, b1_q});
        if (mode1_q != 2'd0) begin
            g2_d = $signed({3'b000, g1_q}) + SW'(k_c) + SW'(eg_c);
            b2_d = $signed({3'b000, b1_q}) + SW'(k_c) + SW'(eb_c);
        end
    end

    assign rgb_d = {r2_q, sat8(g2_q), sat8(b2_q)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev_q     <= 1'b0;
            active_mode_q <= '0;
            r1_q          <= '0;
            g1_q          <= '0;
            b1_q          <= '0;
            simr1_q       <= '0;
            simg1_q       <= '0;
            simb1_q       <= '0;
            mode1_q       <= '0;
            sync1_q       <= '0;
            r2_q          <= '0;
            g2_q          <= '0;
            b2_q          <= '0;
            sync2_q       <= '0;
            rgb_q         <= '0;
            sync3_q       <= '0;
        end else if (ce) begin
            vs_prev_q     <= vs_in;
            active_mode_q <= mode_d;
            r1_q          <= r_in_c;
            g1_q          <= g_in_c;
            b1_q          <= b_in_c;
            simr1_q       <= simr_d;
            simg1_q       <= simg_d;
            simb1_q       <= simb_d;
            mode1_q       <= mode_d;
            sync1_q       <= {hs_in, vs_in, de_in};
            r2_q          <= r1_q;
            g2_q          <= g2_d;
            b2_q          <= b2_d;
            sync2_q       <= sync1_q;
            rgb_q         <= rgb_d;
            sync3_q       <= sync2_q;
        end
    end

    assign rgb_out     = rgb_q;
    assign hs_out      = sync3_q[2];
    assign vs_out      = sync3_q[1];
    assign de_out      = sync3_q[0];
    assign active_mode = active_mode_q;

endmodule

// File: tb/tb_color_daltonize.sv
// Directed and randomized checks of color_daltonize against an arithmetic reference model with a three-deep delay line.
module tb_color_daltonize;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [1:0]  deficiency;
    logic [23:0] rgb_in;
    logic        hs_in, vs_in, de_in;
    logic [23:0] rgb_out;
    logic        hs_out, vs_out, de_out;
    logic [1:0]  active_mode;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: latched mode, previous vs, and a three-slot delay line of {rgb, hs, vs, de}.
    logic [1:0]  m_mode;
    logic        m_vsprev;
    logic [26:0] dl [3];

    color_daltonize dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .deficiency (deficiency),
        .rgb_in     (rgb_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .de_in      (de_in),
        .rgb_out    (rgb_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .de_out     (de_out),
        .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    function automatic int clamp255(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] ref_pix(input logic [1:0] m, input logic [23:0] p);
        int r, g, b, sr, sg, sb, pk, k, gg, bb;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        case (m)
            2'd1: begin sr = (160*r + 96*g) / 256;  sg = (179*r + 77*g) / 256;  sb = (77*g + 179*b) / 256;  end
            2'd2: begin sr = (145*r + 111*g) / 256; sg = (143*r + 113*g) / 256; sb = (61*g + 194*b) / 256;  end
            2'd3: begin sr = (243*r + 13*g) / 256;  sg = (111*g + 145*b) / 256; sb = (121*g + 134*b) / 256; end
            default: return p;
        endcase
        pk = 179 * (r - sr);
        k  = (pk >= 0) ? pk / 256 : -((-pk + 255) / 256);
        gg = clamp255(g + k + (g - sg));
        bb = clamp255(b + k + (b - sb));
        return {p[23:16], 8'(gg), 8'(bb)};
    endfunction

    task automatic model_clear();
        m_mode   = 2'd0;
        m_vsprev = 1'b0;
        for (int i = 0; i < 3; i++) dl[i] = '0;
    endtask

    // Advance one clock edge, updating the model with the inputs seen at that edge.
    task automatic tick();
        logic [1:0] m;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (ce) begin
            m        = (vs_in && !m_vsprev) ? deficiency : m_mode;
            m_mode   = m;
            m_vsprev = vs_in;
            dl[2]    = dl[1];
            dl[1]    = dl[0];
            dl[0]    = {ref_pix(m, rgb_in), hs_in, vs_in, de_in};
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_rgb"},  32'(rgb_out),     32'(dl[2][26:3]));
        chk({tag, "_hs"},   32'(hs_out),      32'(dl[2][2]));
        chk({tag, "_vs"},   32'(vs_out),      32'(dl[2][1]));
        chk({tag, "_de"},   32'(de_out),      32'(dl[2][0]));
        chk({tag, "_mode"}, 32'(active_mode), 32'(m_mode));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rgb"},  32'(rgb_out), 32'h0);
        chk({tag, "_sync"}, 32'({hs_out, vs_out, de_out}), 32'h0);
        chk({tag, "_mode"}, 32'(active_mode), 32'h0);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; deficiency = 2'd0; rgb_in = '0;
        hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
        model_clear();
        tick(); tick();
        chk_zero("reset_state");
        reset = 1'b0;

        // Requested mode alone does nothing without a vs edge
        ce = 1'b1; deficiency = 2'd1; rgb_in = 24'h123456; de_in = 1'b1;
        tick(); tick(); tick();
        chk("bypass_rgb", 32'(rgb_out), 32'h123456);
        chk("bypass_mode", 32'(active_mode), 32'd0);
        chk_model("bypass");

        vs_in = 1'b1; tick(); vs_in = 1'b0;
        rgb_in = 24'hFF0000;
        tick(); tick(); tick();
        chk("deut_red", 32'(rgb_out), 32'hFF0043);
        chk("deut_mode", 32'(active_mode), 32'd1);
        chk_model("deut_red");

        rgb_in = 24'h808080;
        tick(); tick(); tick();
        chk("deut_grey", 32'(rgb_out), 32'h808080);
        chk_model("deut_grey");

        deficiency = 2'd2; vs_in = 1'b1; tick(); vs_in = 1'b0; tick();
        rgb_in = 24'h00FF00;
        tick(); tick(); tick();
        chk("prot_green_sat", 32'(rgb_out), 32'h00FF00);
        chk("prot_mode", 32'(active_mode), 32'd2);
        chk_model("prot_green");

        // ce pattern 1,0,0 with random pixels, syncs and modes
        for (int i = 0; i < 300; i++) begin
            ce         = (i % 3 == 0);
            rgb_in     = 24'($urandom);
            hs_in      = 1'($urandom);
            de_in      = 1'($urandom);
            vs_in      = ($urandom_range(0, 7) == 0);
            deficiency = 2'($urandom);
            tick();
            chk_model("rand_ce100");
        end

        // Random ce density
        for (int i = 0; i < 300; i++) begin
            ce         = ($urandom_range(0, 3) != 0);
            rgb_in     = 24'($urandom);
            hs_in      = 1'($urandom);
            de_in      = 1'($urandom);
            vs_in      = ($urandom_range(0, 5) == 0);
            deficiency = 2'($urandom);
            tick();
            chk_model("rand_ce");
        end

        // Establish mode 1, then change the request mid-frame with vs held low
        ce = 1'b1; vs_in = 1'b0; deficiency = 2'd1; tick();
        vs_in = 1'b1; tick(); vs_in = 1'b0;
        deficiency = 2'd3;
        for (int i = 0; i < 5; i++) begin
            rgb_in = 24'($urandom);
            tick();
            chk("midframe_mode", 32'(active_mode), 32'd1);
            chk_model("midframe");
        end

        // Asynchronous reset mid-frame
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        model_clear();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rgb_in = 24'($urandom);
            tick();
            chk("post_reset_mode", 32'(active_mode), 32'd0);
            chk_model("post_reset");
        end
        vs_in = 1'b1; tick(); vs_in = 1'b0;
        chk("trit_mode", 32'(active_mode), 32'd3);
        for (int i = 0; i < 8; i++) begin
            rgb_in = 24'($urandom);
            de_in  = 1'($urandom);
            tick();
            chk_model("trit");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/color_daltonize.md
Name: color_daltonize

Overview:
- Pipelined per-pixel colour-correction stage on the 24-bit RGB video path.
- The colour-deficiency simulation block models what a deficient viewer perceives. This block performs the inverse operation, daltonization: it redistributes the lost error into channels the viewer can still distinguish.
- Sits between the core video output and the scaler/output formatter, clocked on the video clock and qualified by the pixel clock-enable.
- Delays sync/blank signals so they stay aligned with the corrected pixel.

Parameters:
- SHIFT_COEF, 179, Q0.8 weight of the red error added to green and blue (179/256 ≈ 0.7).
- LATENCY, 3, pipeline depth in ce-qualified cycles. Fixed; documentation only, not overridable.

Ports:
- clk  in  1  video clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  pixel clock-enable; the pipeline advances only when ce=1
- deficiency  in  2  requested mode: 0 bypass, 1 deuteranopia, 2 protanopia, 3 tritanopia
- rgb_in  in  24  {R,G,B}, 8 bits each, unsigned
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync, active-high
- de_in  in  1  data enable
- rgb_out  out  24  corrected pixel
- hs_out  out  1  hs_in delayed by 3 ce-cycles
- vs_out  out  1  vs_in delayed by 3 ce-cycles
- de_out  out  1  de_in delayed by 3 ce-cycles
- active_mode  out  2  mode currently in effect

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - All pipeline registers, rgb_out, hs_out, vs_out, de_out clear to 0.
  - active_mode clears to 0 (bypass).
  - Internal vs_prev clears to 0.
- Mode latch:
  - On a ce-cycle where vs_in=1 and vs_prev=0, active_mode <= deficiency.
  - Otherwise active_mode holds; deficiency changes mid-frame are ignored.
  - vs_prev updates only on ce.
  - The mode is carried down the pipeline with each pixel, so a switch never splits one pixel's math.
- Simulation matrices, Q0.8, sim = (a*X + b*Y) >> 8, 16-bit products:
  - mode 1: simR = 160R + 96G; simG = 179R + 77G; simB = 77G + 179B.
  - mode 2: simR = 145R + 111G; simG = 143R + 113G; simB = 61G + 194B.
  - mode 3: simR = 243R + 13G; simG = 111G + 145B; simB = 121G + 134B.
- Stage 1 (ce): register the input pixel, mode, and hs/vs/de; register simR/simG/simB (8-bit, truncated).
- Stage 2 (ce): compute signed 9-bit errors eR = R - simR, eG = G - simG, eB = B - simB.
  - k = (SHIFT_COEF * eR) >>> 8, arithmetic shift (floors toward -inf), signed 10-bit.
  - Register the signed 11-bit sums: g = G + k + eG; b = B + k + eB. R passes unchanged.
- Stage 3 (ce): saturate each channel (<0 → 0, >255 → 255) and drive rgb_out = {R, sat(g), sat(b)}.
- Bypass (mode 0): rgb_out equals rgb_in 3 ce-cycles later, same latency as the active modes.
- Latency is exactly 3 ce-cycles for rgb, hs, vs, de. When ce=0, all registers and outputs hold.
- Blanking (de=0) pixels are processed identically; no forcing to black.
- Reset mid-frame: outputs go to 0 immediately and the mode returns to bypass until the next vs rising edge.
- vs_in rising on the same ce-cycle as a deficiency change: the new deficiency value is latched.

Test Plan:
- Reset, then ce=1 with deficiency=1 held, no vs edge; rgb_in=0x123456 → rgb_out=0x123456 after 3 cycles (still bypass).
- vs pulse with deficiency=1, then rgb_in=0xFF0000 → rgb_out=0xFF0043 at 3-cycle latency; active_mode=1.
- Mode 1, rgb_in=0x808080 → rgb_out=0x808080 (zero error, grey invariance).
- Mode 2, rgb_in=0x00FF00 → rgb_out=0x00FF00: g saturates high (321→255), b saturates low (-137→0).
- ce toggling 1,0,0,1,... with random pixels and hs/vs/de → output equals the reference model delayed by exactly 3 ce-high cycles; outputs stable while ce=0.
- deficiency changed mid-frame, then reset asserted mid-frame → active_mode updates only at the vs rising edge; on reset all outputs are 0 asynchronously and active_mode=0.
